// File: rtl/servo_pkg.sv
// servo_pkg: shared constants and arithmetic helpers for the servo PWM generator.
//   US_PER_S  - microseconds per second, used to derive the clock prescaler
//   clamp_us  - limit a requested width to [lo, hi]
//   slew_step - move a current width toward a target by at most 'step' (0 = jump)
package servo_pkg;

  localparam int unsigned US_PER_S = 1_000_000;

  // Clamp a requested pulse width into the safe window.
  function automatic int unsigned clamp_us(input int unsigned us,
                                           input int unsigned lo,
                                           input int unsigned hi);
    int unsigned res;
    res = us;
    if (us < lo) res = lo;
    if (us > hi) res = hi;
    return res;
  endfunction

  // Unsigned step toward target; compares before subtracting so nothing wraps.
  function automatic int unsigned slew_step(input int unsigned cur,
                                            input int unsigned tgt,
                                            input int unsigned step);
    int unsigned res;
    res = tgt;
    if (step != 0) begin
      if (tgt > cur) begin
        if ((tgt - cur) > step) res = cur + step;
      end else begin
        if ((cur - tgt) > step) res = cur - step;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/servo_slew_ch.sv
// servo_slew_ch: one servo channel - target/current width registers and pulse compare.
//   clk, rst_n     clock, async active-low reset
//   enable         output enable; low forces pwm low on the next clock
//   wr, wr_us      accepted command for this channel and its requested width
//   update         frame-wrap cycle; current width slews toward target here only
//   us_cnt         microsecond position within the frame
//   pwm            registered pulse output
//   settled_nxt_c  current == target in the state about to be registered
module servo_slew_ch
  import servo_pkg::*;
#(
  parameter int unsigned US_W      = 16,
  parameter int unsigned CNT_W     = 15,
  parameter int unsigned MIN_US    = 1000,
  parameter int unsigned MAX_US    = 2000,
  parameter int unsigned CENTER_US = 1500,
  parameter int unsigned SLEW_US   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             wr,
  input  logic [US_W-1:0]  wr_us,
  input  logic             update,
  input  logic [CNT_W-1:0] us_cnt,
  output logic             pwm,
  output logic             settled_nxt_c
);

  logic [US_W-1:0] target_q;
  logic [US_W-1:0] cur_q;
  logic [US_W-1:0] target_nxt_c;
  logic [US_W-1:0] cur_nxt_c;

  // Next target/current; commands never coincide with update (cmd_ready is low then).
  always_comb begin
    target_nxt_c = target_q;
    cur_nxt_c    = cur_q;
    if (wr) begin
      target_nxt_c = US_W'(clamp_us(32'(wr_us), MIN_US, MAX_US));
    end
    if (update) begin
      cur_nxt_c = US_W'(slew_step(32'(cur_q), 32'(target_q), SLEW_US));
    end
    settled_nxt_c = (target_nxt_c == cur_nxt_c);
  end

  // Width registers and pulse output; cur only changes at the frame wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= US_W'(CENTER_US);
      cur_q    <= US_W'(CENTER_US);
      pwm      <= 1'b0;
    end else begin
      target_q <= target_nxt_c;
      cur_q    <= cur_nxt_c;
      pwm      <= enable && (32'(us_cnt) < 32'(cur_q));
    end
  end

endmodule

// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: multi-channel RC-servo PWM generator sharing one frame.
//   clk, rst_n            clock, async active-low reset
//   enable                global output enable (timebase keeps running when low)
//   cmd_valid/cmd_ready   command handshake; ready drops only on the frame-wrap cycle
//   cmd_ch, cmd_us        channel index and requested width in microseconds
//   cmd_err               one-cycle pulse for an accepted out-of-range channel
//   servo_pwm             per-channel pulse outputs
//   frame_start           one-cycle pulse on the first cycle of each frame
//   settled               every channel's current width equals its target
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 25_000_000,
  parameter int unsigned N_CH      = 4,
  parameter int unsigned FRAME_US  = 20000,
  parameter int unsigned MIN_US    = 1000,
  parameter int unsigned MAX_US    = 2000,
  parameter int unsigned CENTER_US = 1500,
  parameter int unsigned SLEW_US   = 0,
  parameter int unsigned US_W      = 16,
  parameter int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [CH_W-1:0] cmd_ch,
  input  logic [US_W-1:0] cmd_us,
  output logic            cmd_err,
  output logic [N_CH-1:0] servo_pwm,
  output logic            frame_start,
  output logic            settled
);

  localparam int unsigned DIV   = CLK_HZ / US_PER_S;
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CNT_W = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_nxt_c;
  logic [CNT_W-1:0] us_cnt_q;
  logic [CNT_W-1:0] us_cnt_nxt_c;
  logic             us_tick_c;
  logic             update_c;
  logic             update_nxt_c;
  logic             accept_c;
  logic             ch_bad_c;
  logic [N_CH-1:0]  wr_c;
  logic [N_CH-1:0]  ch_settled_c;

  // Timebase, frame wrap and command decode.
  always_comb begin
    us_tick_c    = (pre_q == PRE_W'(DIV - 1));
    pre_nxt_c    = us_tick_c ? '0 : pre_q + PRE_W'(1);
    update_c     = us_tick_c && (us_cnt_q == CNT_W'(FRAME_US - 1));
    us_cnt_nxt_c = us_cnt_q;
    if (update_c) begin
      us_cnt_nxt_c = '0;
    end else if (us_tick_c) begin
      us_cnt_nxt_c = us_cnt_q + CNT_W'(1);
    end
    // Look one cycle ahead so the registered cmd_ready is low exactly on the wrap.
    update_nxt_c = (pre_nxt_c == PRE_W'(DIV - 1)) &&
                   (us_cnt_nxt_c == CNT_W'(FRAME_US - 1));
    accept_c     = cmd_valid && cmd_ready;
    ch_bad_c     = (32'(cmd_ch) >= N_CH);
  end

  // Per-channel width state and pulse generation.
  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    assign wr_c[ch] = accept_c && (cmd_ch == CH_W'(ch));

    servo_slew_ch #(
      .US_W      (US_W),
      .CNT_W     (CNT_W),
      .MIN_US    (MIN_US),
      .MAX_US    (MAX_US),
      .CENTER_US (CENTER_US),
      .SLEW_US   (SLEW_US)
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .wr            (wr_c[ch]),
      .wr_us         (cmd_us),
      .update        (update_c),
      .us_cnt        (us_cnt_q),
      .pwm           (servo_pwm[ch]),
      .settled_nxt_c (ch_settled_c[ch])
    );
  end

  // Timebase and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q       <= '0;
      us_cnt_q    <= '0;
      cmd_ready   <= 1'b1;
      cmd_err     <= 1'b0;
      frame_start <= 1'b0;
      settled     <= 1'b1;
    end else begin
      pre_q       <= pre_nxt_c;
      us_cnt_q    <= us_cnt_nxt_c;
      cmd_ready   <= !update_nxt_c;
      cmd_err     <= accept_c && ch_bad_c;
      frame_start <= update_c;
      settled     <= &ch_settled_c;
    end
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb_servo_pwm_multi: randomized self-checking bench for servo_pwm_multi.
// Two instances share stimulus: u_dut_a jumps immediately, u_dut_b slews 100 us/frame.
module tb_servo_pwm_multi;

  localparam int N_CH      = 4;
  localparam int DIV       = 2;
  localparam int FRAME_US  = 3000;
  localparam int P         = FRAME_US * DIV;
  localparam int MIN_US    = 1000;
  localparam int MAX_US    = 2000;
  localparam int CENTER_US = 1500;
  localparam int SLEW_B    = 100;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic            cmd_valid;
  logic [2:0]      cmd_ch;
  logic [15:0]     cmd_us;
  logic            ready_a, err_a, fs_a, settled_a;
  logic            ready_b, err_b, fs_b, settled_b;
  logic [N_CH-1:0] pwm_a, pwm_b;

  always #5 clk = ~clk;

  servo_pwm_multi #(
    .CLK_HZ(2_000_000), .N_CH(N_CH), .FRAME_US(FRAME_US), .MIN_US(MIN_US),
    .MAX_US(MAX_US), .CENTER_US(CENTER_US), .SLEW_US(0), .US_W(16), .CH_W(3)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cmd_valid(cmd_valid),
    .cmd_ready(ready_a), .cmd_ch(cmd_ch), .cmd_us(cmd_us), .cmd_err(err_a),
    .servo_pwm(pwm_a), .frame_start(fs_a), .settled(settled_a)
  );

  servo_pwm_multi #(
    .CLK_HZ(2_000_000), .N_CH(N_CH), .FRAME_US(FRAME_US), .MIN_US(MIN_US),
    .MAX_US(MAX_US), .CENTER_US(CENTER_US), .SLEW_US(SLEW_B), .US_W(16), .CH_W(3)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cmd_valid(cmd_valid),
    .cmd_ready(ready_b), .cmd_ch(cmd_ch), .cmd_us(cmd_us), .cmd_err(err_b),
    .servo_pwm(pwm_b), .frame_start(fs_b), .settled(settled_b)
  );

  // Reference model: clock count since reset release, per-channel widths.
  int n;
  int ph;
  int tgt   [N_CH];
  int cur_a [N_CH];
  int cur_b [N_CH];
  int cnt_a [N_CH];
  int cnt_b [N_CH];
  bit win_en;
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int clamp_ref(input int v);
    if (v < MIN_US) return MIN_US;
    if (v > MAX_US) return MAX_US;
    return v;
  endfunction

  function automatic int step_ref(input int c, input int t, input int s);
    int d;
    d = t - c;
    if (s == 0 || (d <= s && d >= -s)) return t;
    return (d > 0) ? c + s : c - s;
  endfunction

  function automatic logic [N_CH-1:0] exp_bits(input int which);
    logic [N_CH-1:0] b;
    for (int ch = 0; ch < N_CH; ch++) begin
      b[ch] = enable && ph >= 1 &&
              ph <= ((which == 0) ? cur_a[ch] : cur_b[ch]) * DIV;
    end
    return b;
  endfunction

  task automatic model_reset();
    n = 0;
    ph = 0;
    win_en = 1'b1;
    for (int ch = 0; ch < N_CH; ch++) begin
      tgt[ch]   = CENTER_US;
      cur_a[ch] = CENTER_US;
      cur_b[ch] = CENTER_US;
      cnt_a[ch] = 0;
      cnt_b[ch] = 0;
    end
  endtask

  // Advance one clock, sample at the falling edge and score against the model.
  task automatic tick();
    bit sa, sb;
    @(negedge clk);
    n++;
    ph = n % P;
    if (ph == 0) begin
      sa = 1'b1;
      sb = 1'b1;
      for (int ch = 0; ch < N_CH; ch++) begin
        check($sformatf("width_a%0d", ch), cnt_a[ch], win_en ? cur_a[ch] * DIV : 0);
        check($sformatf("width_b%0d", ch), cnt_b[ch], win_en ? cur_b[ch] * DIV : 0);
        cur_a[ch] = step_ref(cur_a[ch], tgt[ch], 0);
        cur_b[ch] = step_ref(cur_b[ch], tgt[ch], SLEW_B);
        cnt_a[ch] = 0;
        cnt_b[ch] = 0;
        if (cur_a[ch] != tgt[ch]) sa = 1'b0;
        if (cur_b[ch] != tgt[ch]) sb = 1'b0;
      end
      check("settled_a", settled_a, sa);
      check("settled_b", settled_b, sb);
    end
    for (int ch = 0; ch < N_CH; ch++) begin
      cnt_a[ch] += int'(pwm_a[ch]);
      cnt_b[ch] += int'(pwm_b[ch]);
    end
    if (ph == 1) begin
      win_en = enable;
      if (!enable) begin
        check("dis_pwm_a", pwm_a, 0);
        check("dis_pwm_b", pwm_b, 0);
      end
    end
    if (ph == 0 || ph == 1 || ph == P - 1) begin
      check("frame_start_a", fs_a, ph == 0);
      check("frame_start_b", fs_b, ph == 0);
      check("cmd_ready_a", ready_a, ph != P - 1);
      check("cmd_ready_b", ready_b, ph != P - 1);
    end
  endtask

  task automatic wait_n(input int t);
    while (n < t) tick();
  endtask

  // One-clock command; caller guarantees it is not issued on the wrap cycle.
  task automatic send_cmd(input int ch, input int us);
    check("ready_pre_a", ready_a, 1);
    check("ready_pre_b", ready_b, 1);
    cmd_valid = 1'b1;
    cmd_ch    = 3'(ch);
    cmd_us    = 16'(us);
    if (ch < N_CH) tgt[ch] = clamp_ref(us);
    tick();
    cmd_valid = 1'b0;
    check("cmd_err_a", err_a, ch >= N_CH);
    check("cmd_err_b", err_b, ch >= N_CH);
    tick();
    check("cmd_err_clr_a", err_a, 0);
    check("cmd_err_clr_b", err_b, 0);
  endtask

  task automatic reset_checks();
    check("rst_pwm_a", pwm_a, 0);
    check("rst_pwm_b", pwm_b, 0);
    check("rst_ready_a", ready_a, 1);
    check("rst_ready_b", ready_b, 1);
    check("rst_settled_a", settled_a, 1);
    check("rst_settled_b", settled_b, 1);
    check("rst_fs_a", fs_a, 0);
    check("rst_err_a", err_a, 0);
    check("rst_err_b", err_b, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b1;
    cmd_valid = 1'b0;
    cmd_ch    = '0;
    cmd_us    = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_checks();
    rst_n = 1'b1;

    // Frame 1: fixed commands, including clamping at both ends.
    wait_n(P + 1000);
    send_cmd(1, 1800);
    send_cmd(2, 500);
    send_cmd(3, 2500);
    send_cmd(0, 1800);

    // Frames 2..4: random commands, channel 0 left alone so its slew is visible.
    for (int f = 2; f <= 4; f++) begin
      wait_n(f * P + 500);
      repeat (6) begin
        send_cmd(int'($urandom_range(1, 7)), int'($urandom_range(0, 3000)));
        repeat ($urandom_range(1, 50)) tick();
      end
    end

    // Frame 5: out-of-range channel, then valid held across the wrap cycle.
    wait_n(5 * P + 1000);
    send_cmd(5, 1234);
    wait_n(6 * P - 1);
    cmd_valid = 1'b1;
    cmd_ch    = 3'd0;
    cmd_us    = 16'($urandom_range(0, 3000));
    tick();
    tgt[0] = clamp_ref(int'(cmd_us));
    enable = 1'b0;
    tick();
    cmd_valid = 1'b0;
    check("held_err_a", err_a, 0);

    // Frame 6 disabled; frame 7 re-enabled then reset mid-pulse.
    wait_n(7 * P);
    enable = 1'b1;
    wait_n(7 * P + 1000);
    check("pre_rst_a", pwm_a, exp_bits(0));
    check("pre_rst_b", pwm_b, exp_bits(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_a", pwm_a, 0);
    check("async_rst_b", pwm_b, 0);
    repeat (2) @(negedge clk);
    reset_checks();
    rst_n = 1'b1;
    model_reset();
    wait_n(2 * P + 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/servo_pwm_multi.md
# servo_pwm_multi

Parametrised multi-channel RC-servo PWM generator. Derives a 1 µs timebase from the system clock and emits one shared-frame pulse per channel. Each pulse width is commanded in microseconds through a valid/ready port, clamped to a safe range, and approached at a programmable slew rate per frame. It replaces single-pin toggle testing as the servo driver behind the board's control logic and status LEDs.

## Interface
- CLK_HZ, 25_000_000: system clock frequency; must be an integer multiple of 1_000_000.
- N_CH, 4: number of servo channels (1..16).
- FRAME_US, 20000: frame period in µs.
- MIN_US, 1000: minimum pulse width in µs.
- MAX_US, 2000: maximum pulse width in µs; must be < FRAME_US.
- CENTER_US, 1500: reset target and current width for every channel.
- SLEW_US, 0: maximum change of current width per frame in µs; 0 means an immediate jump.
- US_W, 16: width of the command and width registers.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  global output enable; when low, all pwm outputs are 0 and the timebase keeps running.
- cmd_valid  in  1  command strobe.
- cmd_ready  out  1  command accept.
- cmd_ch  in  $clog2(N_CH) (min 1)  channel index.
- cmd_us  in  US_W  requested pulse width in µs.
- cmd_err  out  1  one-cycle pulse when an accepted cmd_ch is ≥ N_CH.
- servo_pwm  out  N_CH  per-channel pulse outputs.
- frame_start  out  1  one-cycle pulse on the first cycle of each frame.
- settled  out  1  high when current width equals target width on every channel.

## Operation
- Reset values:
  - servo_pwm = 0, frame_start = 0, cmd_err = 0, cmd_ready = 1, settled = 1.
  - Prescaler = 0, us_cnt = 0.
  - All target and cur registers = CENTER_US.
- Prescaler:
  - Counts 0..DIV-1, where DIV = CLK_HZ/1_000_000.
  - us_tick is asserted when the prescaler equals DIV-1.
- Frame counter:
  - us_cnt increments on us_tick.
  - From FRAME_US-1 it wraps to 0.
  - The wrap cycle (us_tick && us_cnt == FRAME_US-1) is the update cycle.
- Command accept:
  - Accepted when cmd_valid && cmd_ready.
  - target[cmd_ch] <= clamp(cmd_us, MIN_US, MAX_US).
  - Out-of-range cmd_ch: command is consumed, no register changes, cmd_err pulses.
  - Commands to the same channel overwrite each other; the last accepted command wins.
- cmd_ready is 0 only on the update cycle. This prevents collisions between commands and slew updates.
- Slew, applied on the update cycle for every channel:
  - If SLEW_US == 0 or |target-cur| ≤ SLEW_US: cur <= target.
  - Otherwise cur moves SLEW_US toward target.
  - All arithmetic is unsigned on US_W bits, comparing before subtracting; no wrap-around.
- Output: servo_pwm[ch] <= enable && (us_cnt < cur[ch]). The result is a high pulse of exactly cur×DIV clock cycles per frame.
- settled is registered from the post-update state. It is combinational over all channels, then registered.

## Timing
- frame_start is registered from the update cycle, so it is high during the first clock of us_cnt == 0.
- servo_pwm lags us_cnt by one clock. Every channel rises on the same clock, the cycle after the wrap.
- A command accepted in frame k takes effect no earlier than frame k+1. With SLEW_US = 0 it reaches full width in frame k+1.
- A new cur value is never applied mid-frame, so no glitched or truncated pulses occur.
- Deasserting enable forces all outputs low on the next clock. Reasserting it resumes output mid-frame according to the comparison, which may produce a partial first pulse.
- Asserting rst_n low mid-pulse drives servo_pwm low immediately (asynchronously) and restores CENTER_US on all channels.

## Structure
- Package servo_pkg holds:
  - the US_PER_S = 1_000_000 constant;
  - a clamp_us function;
  - the slew_step function (unsigned toward-target step).
- Sub-module servo_slew_ch, instantiated once per channel (generate loop), holds:
  - the target and cur registers;
  - the accept and update logic;
  - the comparison outputs.
- The top level holds the prescaler, us_cnt, command decode and cmd_err.

## Test plan
All scenarios use CLK_HZ=2_000_000 (DIV=2), FRAME_US=3000, N_CH=4 unless stated.
- Reset, then run 2 frames -> all channels pulse 1500 µs (3000 clocks) per frame, frame_start period 6000 clocks, settled = 1.
- cmd ch1 = 1800 mid-frame -> ch1 stays 1500 in the current frame and is 1800 from the next frame; other channels unchanged.
- cmd ch2 = 500 and ch3 = 2500 -> pulses clamped to 1000 and 2000.
- SLEW_US=100, cmd ch0 = 1800 -> widths 1600, 1700, 1800 in consecutive frames; settled low until the 1800 frame, then high.
- cmd_valid held through the update cycle -> cmd_ready low exactly 1 clock, command accepted the next clock. cmd_ch = 5 (N_CH = 4, with the index width set to 3 bits) -> cmd_err pulses once with no state change.
- enable low for 1 frame, then rst_n pulsed mid-pulse -> outputs zero during the disabled frame. Reset forces outputs low asynchronously, after which all channels return to 1500.
